// File: rtl/mbe_product_accumulator.sv
// mbe_product_accumulator
//   Sums signed 2*N-bit products from the multiplier stage into a signed
//   accumulator with GUARD extra bits. A frame closes after FRAME_LEN beats
//   or on an early in_last. The frame sum, its beat count and its overflow
//   flag are then offered on a registered valid/ready output.
//   Optional feature macro: MAC_SAT_EN (saturating accumulate plus a sticky
//   per-frame overflow flag). Without it the accumulator wraps and out_ovf is 0.
module mbe_product_accumulator #(
  parameter  int N         = 32,
  parameter  int FRAME_LEN = 16,
  parameter  int GUARD     = 2,
  localparam int PW        = 2 * N,
  localparam int ACC_W     = PW + GUARD,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ACC,
    ST_SEND
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               in_ready_reg, in_ready_next;
  logic               out_valid_reg, out_valid_next;
  logic [ACC_W-1:0]   out_data_reg, out_data_next;
  logic [CNT_W-1:0]   out_count_reg, out_count_next;

  logic [ACC_W-1:0]   acc_sum;   // accumulator plus current product (wrapped or clamped)
  logic               beat;      // a product is taken this cycle
  logic               closing;   // the accepted product ends the frame

  assign beat    = (state_reg == ST_ACC) && in_valid && in_ready_reg;
  assign closing = beat && ((cnt_reg == LAST_CNT) || in_last);

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0]     sum_wide;
  logic               ovf_now;
  logic               ovf_reg;
  logic               out_ovf_reg;

  // One extra bit exposes signed overflow; on overflow clamp toward the true sign.
  always_comb begin
    sum_wide = {acc_reg[ACC_W-1], acc_reg} + {{(GUARD+1){in_data[PW-1]}}, in_data};
    ovf_now  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
    acc_sum  = sum_wide[ACC_W-1:0];
    if (ovf_now) begin
      acc_sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Sticky overflow flag for the running frame, published with the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg     <= 1'b0;
      out_ovf_reg <= 1'b0;
    end else if ((state_reg == ST_SEND) && out_ready) begin
      ovf_reg     <= 1'b0;
      out_ovf_reg <= 1'b0;
    end else if (beat) begin
      ovf_reg <= ovf_reg | ovf_now;
      if (closing) begin
        out_ovf_reg <= ovf_reg | ovf_now;
      end
    end
  end

  assign out_ovf = out_ovf_reg;
`else
  // Plain modulo-2^ACC_W accumulate.
  always_comb begin
    acc_sum = acc_reg + {{GUARD{in_data[PW-1]}}, in_data};
  end

  assign out_ovf = 1'b0;
`endif

  // Next-state and registered-output logic for INIT -> ACC -> SEND -> ACC.
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    in_ready_next  = in_ready_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_count_next = out_count_reg;
    case (state_reg)
      ST_INIT: begin
        in_ready_next = 1'b1;
        state_next    = ST_ACC;
      end
      ST_ACC: begin
        if (beat) begin
          acc_next = acc_sum;
          cnt_next = cnt_reg + CNT_W'(1);
          if (closing) begin
            out_data_next  = acc_sum;
            out_count_next = cnt_reg + CNT_W'(1);
            out_valid_next = 1'b1;
            in_ready_next  = 1'b0;
            state_next     = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // Result stays put until taken; no product is accepted meanwhile.
        if (out_ready) begin
          out_valid_next = 1'b0;
          acc_next       = '0;
          cnt_next       = '0;
          in_ready_next  = 1'b1;
          state_next     = ST_ACC;
        end
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_count_reg <= out_count_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;

endmodule

// File: tb/tb_mbe_product_accumulator.sv
// tb_mbe_product_accumulator
//   Directed scoreboard bench: stimulus pushes hand-computed frame results,
//   a monitor pops and compares on every output handshake.
module tb_mbe_product_accumulator;

  localparam int N     = 32;
  localparam int FL    = 16;
  localparam int PW    = 2 * N;
  localparam int ACC_W = PW + 2;
  localparam int CNT_W = $clog2(FL + 1);

  typedef struct {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             ovf;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mbe_product_accumulator #(.N(N), .FRAME_LEN(FL), .GUARD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic expect_frame(input string name, input logic [ACC_W-1:0] d,
                              input int cnt, input logic ovf);
    exp_t e;
    e.data  = d;
    e.count = CNT_W'(cnt);
    e.ovf   = ovf;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compare each presented result as it is handed off.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_data"}, out_data, e.data);
        check({e.name, "_count"}, ACC_W'(out_count), ACC_W'(e.count));
        check({e.name, "_ovf"}, ACC_W'(out_ovf), ACC_W'(e.ovf));
      end
    end
  end

  // Offer one beat and hold it until accepted; waits reports negedges spent waiting.
  task automatic beat(input logic [PW-1:0] d, input logic last, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waits    = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!in_ready && waits < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, ACC_W'(exp_q.size()), '0);
  endtask

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset held for two cycles
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", ACC_W'(in_ready), '0);
      check("rst_out_valid", ACC_W'(out_valid), '0);
      check("rst_out_data", out_data, '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_c1", ACC_W'(in_ready), '0);
    @(negedge clk);
    check("post_rst_ready_c2", ACC_W'(in_ready), ACC_W'(1));
    @(posedge clk);
    #1;

    // Full frame, back-to-back beats of 3
    expect_frame("full", ACC_W'(48), 16, 1'b0);
    for (int i = 0; i < FL; i++) begin
      beat(PW'(3), 1'b0, w);
      check("full_no_bubble", ACC_W'(w), ACC_W'(1));
    end
    check("full_valid_latency", ACC_W'(out_valid), ACC_W'(1));

    // Early close via in_last
    expect_frame("early", ACC_W'(12), 3, 1'b0);
    beat(PW'(-5), 1'b0, w);
    beat(PW'(7), 1'b0, w);
    beat(PW'(10), 1'b1, w);
    check("early_valid_latency", ACC_W'(out_valid), ACC_W'(1));
    wait_drain("early");

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    expect_frame("bp", ACC_W'(10), 4, 1'b0);
    beat(PW'(1), 1'b0, w);
    beat(PW'(2), 1'b0, w);
    beat(PW'(3), 1'b0, w);
    beat(PW'(4), 1'b1, w);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", ACC_W'(out_valid), ACC_W'(1));
      check("bp_hold_data", out_data, ACC_W'(10));
      check("bp_hold_count", ACC_W'(out_count), ACC_W'(4));
      check("bp_in_ready_low", ACC_W'(in_ready), '0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_after_hs", ACC_W'(in_ready), ACC_W'(1));
    check("bp_valid_after_hs", ACC_W'(out_valid), '0);
    expect_frame("after_bp", ACC_W'(-10), 2, 1'b0);
    beat(PW'(20), 1'b0, w);
    beat(PW'(-30), 1'b1, w);
    wait_drain("after_bp");

    // Overflow: 16 x 2^62 reaches 2^66
`ifdef MAC_SAT_EN
    expect_frame("ovf", {1'b0, {(ACC_W-1){1'b1}}}, 16, 1'b1);
`else
    expect_frame("ovf", '0, 16, 1'b0);
`endif
    for (int i = 0; i < FL; i++) begin
      beat(64'h4000_0000_0000_0000, 1'b0, w);
    end
    wait_drain("ovf");

    // Reset in mid-frame discards the partial sum
    for (int i = 0; i < 5; i++) begin
      beat(PW'(100), 1'b0, w);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", ACC_W'(out_valid), '0);
    check("midrst_in_ready", ACC_W'(in_ready), '0);
    expect_frame("midrst", ACC_W'(16), 16, 1'b0);
    for (int i = 0; i < FL; i++) begin
      beat(PW'(1), 1'b0, w);
    end
    wait_drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on simulated time.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
